// File: rtl/program_loader_if.sv
// Host write port of the program loader: one image word per valid/ready handshake.
interface program_loader_if #(
  parameter int N = 4
);
  logic         wr_valid;
  logic         wr_ready;
  logic [7:0]   wr_prog;
  logic [N-1:0] wr_data;
  logic         wr_last;

  modport master (output wr_valid, wr_prog, wr_data, wr_last, input wr_ready);
  modport slave  (input wr_valid, wr_prog, wr_data, wr_last, output wr_ready);
endinterface

// File: rtl/program_loader.sv
// Buffers a 16-entry program/data image from a host, then replays it to the CPU
// as 16 three-cycle load strobes before enabling the CPU run clock.
module program_loader #(
  parameter int N     = 4,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  program_loader_if.slave        wr,
  input  logic                   start,
  output logic                   ld_clk,
  output logic [7:0]             ld_prog,
  output logic [N-1:0]           ld_data,
  output logic [4:0]             fill_count,
  output logic                   busy,
  output logic                   cpu_go
);

  typedef enum logic [2:0] {FILL, LOADED, SETUP, PULSE, HOLD, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);
  localparam logic [7:0] HLT      = 8'hF0;

  state_t       state;
  logic [4:0]   idx;
  logic [4:0]   next_idx;
  logic         accept;
  logic [7:0]   entry_prog;
  logic [N-1:0] entry_data;

  logic [7:0]   prog_mem [DEPTH];
  logic [N-1:0] data_mem [DEPTH];

  assign accept = wr.wr_valid & wr.wr_ready;

  // Index of the entry presented on the next entry into SETUP.
  assign next_idx = (state == HOLD) ? idx + 5'd1 : 5'd0;

  // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
  always_comb begin
    entry_prog = HLT;
    entry_data = '0;
    if (next_idx < fill_count) begin
      entry_prog = prog_mem[next_idx[3:0]];
      entry_data = data_mem[next_idx[3:0]];
    end
  end

  // NOTE: image storage has no reset; unwritten entries are masked by the padding mux.
  always_ff @(posedge clk) begin
    if (state == FILL && accept) begin
      prog_mem[fill_count[3:0]] <= wr.wr_prog;
      data_mem[fill_count[3:0]] <= wr.wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      idx         <= '0;
      wr.wr_ready <= 1'b0;
      ld_clk      <= 1'b0;
      ld_prog     <= '0;
      ld_data     <= '0;
      fill_count  <= '0;
      busy        <= 1'b0;
      cpu_go      <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          wr.wr_ready <= 1'b1;
          if (accept) begin
            fill_count <= fill_count + 5'd1;
            // Either marker closes the image; on the 16th word with wr_last both agree.
            if (wr.wr_last || fill_count == LAST_IDX) begin
              state       <= LOADED;
              wr.wr_ready <= 1'b0;
            end
          end
        end
        LOADED: begin
          if (start) begin
            state   <= SETUP;
            idx     <= next_idx;
            ld_prog <= entry_prog;
            ld_data <= entry_data;
            busy    <= 1'b1;
          end
        end
        SETUP: begin
          state  <= PULSE;
          ld_clk <= 1'b1;
        end
        PULSE: begin
          state  <= HOLD;
          ld_clk <= 1'b0;
        end
        HOLD: begin
          if (idx == LAST_IDX) begin
            state  <= DONE;
            busy   <= 1'b0;
            cpu_go <= 1'b1;
          end else begin
            state   <= SETUP;
            idx     <= next_idx;
            ld_prog <= entry_prog;
            ld_data <= entry_data;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule
